// File: rtl/aes_bist_seq_pkg.sv
// Shared definitions for the AES BIST sequencer: FSM states, key-mode codes,
// LFSR polynomial and the signature fold.
package aes_bist_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_ENC_REQ, S_ENC_WAIT, S_DEC_REQ, S_DEC_WAIT, S_CHECK, S_NEXT, S_DONE
  } state_t;

  localparam logic [1:0] MODE_128 = 2'b00;
  localparam logic [1:0] MODE_192 = 2'b01;
  localparam logic [1:0] MODE_256 = 2'b10;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

  // MISR: rotate left by one, then xor in the four ciphertext words
  function automatic logic [31:0] sig_fold(input logic [31:0] sig, input logic [127:0] blk);
    return {sig[30:0], sig[31]} ^ blk[127:96] ^ blk[95:64] ^ blk[63:32] ^ blk[31:0];
  endfunction

endpackage

// File: rtl/aes_bist_seq_lfsr.sv
// 32-bit Galois LFSR; reset and load both restore the seed, step advances once.
module aes_bist_seq_lfsr
  import aes_bist_seq_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2468
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  output logic [31:0] q
);

  always_ff @(posedge clk) begin
    if (reset || load) q <= SEED;
    else if (step)     q <= lfsr_step(q);
  end

endmodule

// File: rtl/aes_bist_seq.sv
// BIST sequencer: generates LFSR plaintext/key pairs per enabled key mode,
// runs encrypt then decrypt on the AES core and checks the round trip.
module aes_bist_seq
  import aes_bist_seq_pkg::*;
#(
  parameter int          NUM_VECTORS    = 4,
  parameter logic [2:0]  MODE_MASK      = 3'b111,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] SEED           = 32'hACE1_2468
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         core_start,
  output logic         core_dec,
  output logic [1:0]   core_mode,
  output logic [255:0] core_key,
  output logic [127:0] core_din,
  input  logic         core_done,
  input  logic [127:0] core_dout,
  output logic         busy,
  output logic         done,
  output logic         led128,
  output logic         led192,
  output logic         led256,
  output logic [7:0]   fail_count,
  output logic [31:0]  signature
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t         state, nstate;
  logic [3:0]     ld_cnt;
  logic [TW-1:0]  wait_cnt;
  logic [7:0]     vec_cnt;
  logic [127:0]   pt, ct, rt;
  logic [255:0]   key;
  logic [2:0]     flags;
  logic [31:0]    lfsr_q;
  logic           idle_start, last_vec, tmo, nxt_ok;
  logic [1:0]     nxt_mode, first_mode;
  logic [7:0]     fc_inc;

  assign idle_start = start && (state == S_IDLE || state == S_DONE);
  assign last_vec   = (vec_cnt == 8'(NUM_VECTORS - 1));
  assign tmo        = !core_done && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign fc_inc     = (fail_count == 8'hFF) ? fail_count : fail_count + 8'd1;

  // Descending scan leaves the lowest qualifying mode as the winner
  always_comb begin
    first_mode = MODE_128;
    nxt_mode   = core_mode;
    nxt_ok     = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      if (MODE_MASK[i]) first_mode = 2'(i);
      if (MODE_MASK[i] && (2'(i) > core_mode)) begin
        nxt_mode = 2'(i);
        nxt_ok   = 1'b1;
      end
    end
  end

  aes_bist_seq_lfsr #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (idle_start),
    .step  (state == S_LOAD),
    .q     (lfsr_q)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE, S_DONE: if (start) nstate = (MODE_MASK == 3'b000) ? S_DONE : S_LOAD;
      S_LOAD:         if (ld_cnt == 4'd11) nstate = S_ENC_REQ;
      S_ENC_REQ:      nstate = S_ENC_WAIT;
      S_ENC_WAIT:     if (core_done) nstate = S_DEC_REQ; else if (tmo) nstate = S_NEXT;
      S_DEC_REQ:      nstate = S_DEC_WAIT;
      S_DEC_WAIT:     if (core_done) nstate = S_CHECK; else if (tmo) nstate = S_NEXT;
      S_CHECK:        nstate = S_NEXT;
      S_NEXT:         nstate = (last_vec && !nxt_ok) ? S_DONE : S_LOAD;
      default:        nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_cnt     <= '0;
      wait_cnt   <= '0;
      vec_cnt    <= '0;
      pt         <= '0;
      ct         <= '0;
      rt         <= '0;
      key        <= '0;
      flags      <= '0;
      core_mode  <= '0;
      fail_count <= '0;
      signature  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) begin
          fail_count <= '0;
          signature  <= '0;
          flags      <= MODE_MASK;
          core_mode  <= first_mode;
          vec_cnt    <= '0;
          ld_cnt     <= '0;
        end
        S_LOAD: begin
          {pt, key} <= {pt[95:0], key, lfsr_q};
          ld_cnt    <= (ld_cnt == 4'd11) ? 4'd0 : ld_cnt + 4'd1;
        end
        S_ENC_REQ, S_DEC_REQ: wait_cnt <= '0;
        S_ENC_WAIT, S_DEC_WAIT: begin
          if (core_done) begin
            if (state == S_ENC_WAIT) ct <= core_dout;
            else                     rt <= core_dout;
          end else if (tmo) begin
            // timed-out vector contributes an all-zero ciphertext
            fail_count       <= fc_inc;
            flags[core_mode] <= 1'b0;
            signature        <= sig_fold(signature, '0);
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        S_CHECK: begin
          signature <= sig_fold(signature, ct);
          if (rt != pt || ct == pt) begin
            fail_count       <= fc_inc;
            flags[core_mode] <= 1'b0;
          end
        end
        S_NEXT: begin
          if (last_vec) begin
            vec_cnt <= '0;
            if (nxt_ok) core_mode <= nxt_mode;
          end else begin
            vec_cnt <= vec_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign core_start = (state == S_ENC_REQ) || (state == S_DEC_REQ);
  assign core_dec   = (state == S_DEC_REQ);
  assign core_din   = core_dec ? ct : pt;
  assign core_key   = key;
  assign busy       = !(state == S_IDLE || state == S_DONE);
  assign done       = (state == S_DONE);
  assign {led256, led192, led128} = flags & {3{done}};

endmodule

// File: tb/tb_aes_bist_seq.sv
// Bench for aes_bist_seq: loopback xor core with random latency, request
// scoreboard, and end-of-run result checks against a behavioural model.
module tb_aes_bist_seq;

  localparam int          NV   = 2;
  localparam logic [31:0] SEED = 32'hACE1_2468;
  localparam logic [31:0] POLY = 32'h8020_0003;

  logic clk, reset, start;
  logic core_start, core_dec, core_done, busy, done, led128, led192, led256;
  logic [1:0] core_mode;
  logic [255:0] core_key;
  logic [127:0] core_din, core_dout;
  logic [7:0] fail_count;
  logic [31:0] signature;

  logic start1, cs1, cd1, done1_in, busy1, done1, l128_1, l192_1, l256_1;
  logic [1:0] cm1;
  logic [255:0] ck1;
  logic [127:0] cdin1, dout1;
  logic [7:0] fc1;
  logic [31:0] sig1;

  logic start0, cs0, cd0, busy0, done0, l128_0, l192_0, l256_0;
  logic [1:0] cm0;
  logic [255:0] ck0;
  logic [127:0] cdin0;
  logic [7:0] fc0;
  logic [31:0] sig0;
  logic core_done0;
  logic [127:0] core_dout0;
  assign core_done0 = 1'b0;
  assign core_dout0 = '0;

  aes_bist_seq #(.NUM_VECTORS(NV), .MODE_MASK(3'b111), .TIMEOUT_CYCLES(64), .SEED(SEED)) u_dut (
    .clk(clk), .reset(reset), .start(start), .core_start(core_start), .core_dec(core_dec),
    .core_mode(core_mode), .core_key(core_key), .core_din(core_din), .core_done(core_done),
    .core_dout(core_dout), .busy(busy), .done(done), .led128(led128), .led192(led192),
    .led256(led256), .fail_count(fail_count), .signature(signature));

  aes_bist_seq #(.NUM_VECTORS(NV), .MODE_MASK(3'b001), .TIMEOUT_CYCLES(64), .SEED(SEED)) u_m1 (
    .clk(clk), .reset(reset), .start(start1), .core_start(cs1), .core_dec(cd1),
    .core_mode(cm1), .core_key(ck1), .core_din(cdin1), .core_done(done1_in),
    .core_dout(dout1), .busy(busy1), .done(done1), .led128(l128_1), .led192(l192_1),
    .led256(l256_1), .fail_count(fc1), .signature(sig1));

  aes_bist_seq #(.NUM_VECTORS(NV), .MODE_MASK(3'b000), .TIMEOUT_CYCLES(64), .SEED(SEED)) u_m0 (
    .clk(clk), .reset(reset), .start(start0), .core_start(cs0), .core_dec(cd0),
    .core_mode(cm0), .core_key(ck0), .core_din(cdin0), .core_done(core_done0),
    .core_dout(core_dout0), .busy(busy0), .done(done0), .led128(l128_0), .led192(l192_0),
    .led256(l256_0), .fail_count(fc0), .signature(sig0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         dec;
    bit [1:0]   mode;
    bit [127:0] din;
    bit [255:0] key;
  } req_t;

  req_t expq[$];
  req_t mon_e;
  int n_tests = 0, n_fail = 0, nreq = 0;
  int flip_mode = -1, hang_mode = -1;
  int n1 = 0, badmode1 = 0, n0 = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? POLY : 32'h0);
  endfunction

  // Whole-run reference: mask 111, NV vectors per mode, xor loopback core
  task automatic model_run(input int flip, input int hang, output logic [2:0] leds,
                           output logic [7:0] fc, output logic [31:0] sig, output int nexp);
    logic [31:0] l;
    logic [31:0] w[12];
    logic [127:0] pt, ct, rt;
    logic [255:0] key;
    l = SEED; leds = 3'b000; fc = 8'd0; sig = 32'd0; nexp = 0;
    for (int m = 0; m < 3; m++) begin
      leds[m] = 1'b1;
      for (int v = 0; v < NV; v++) begin
        for (int i = 0; i < 12; i++) begin w[i] = l; l = step(l); end
        pt  = {w[0], w[1], w[2], w[3]};
        key = {w[4], w[5], w[6], w[7], w[8], w[9], w[10], w[11]};
        expq.push_back('{1'b0, 2'(m), pt, key}); nexp++;
        if (m == hang) begin
          leds[m] = 1'b0; fc++; sig = {sig[30:0], sig[31]};
          continue;
        end
        ct = pt ^ key[255:128];
        expq.push_back('{1'b1, 2'(m), ct, key}); nexp++;
        rt  = ct ^ key[255:128] ^ ((m == flip) ? 128'd1 : 128'd0);
        sig = {sig[30:0], sig[31]} ^ ct[127:96] ^ ct[95:64] ^ ct[63:32] ^ ct[31:0];
        if (rt != pt || ct == pt) begin leds[m] = 1'b0; fc++; end
      end
    end
  endtask

  // Request monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (core_start === 1'b1) begin
      nreq++;
      if (expq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_req: got dec=%0d mode=%0d, none expected", core_dec, core_mode);
      end else begin
        mon_e = expq.pop_front();
        chk("req_dec_mode", {core_dec, core_mode}, {mon_e.dec, mon_e.mode});
        chk("req_din", core_din, mon_e.din);
        chk("req_key", core_key, mon_e.key);
      end
    end
  end

  // Loopback core for u_dut: random latency, optional decrypt corruption / hang
  initial begin
    bit pend; int cnt; logic [127:0] resp;
    pend = 0; cnt = 0; resp = '0; core_done = 1'b0; core_dout = '0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (reset) pend = 0;
      else begin
        if (pend) begin
          cnt--;
          if (cnt == 0) begin core_done = 1'b1; core_dout = resp; pend = 0; end
        end
        if (core_start && int'(core_mode) != hang_mode) begin
          pend = 1;
          cnt  = $urandom_range(1, 4);
          resp = core_din ^ core_key[255:128] ^
                 ((core_dec && int'(core_mode) == flip_mode) ? 128'd1 : 128'd0);
        end
      end
    end
  end

  // Fixed single-cycle loopback for u_m1, plus request counters for u_m1/u_m0
  initial begin
    bit p1; logic [127:0] r1;
    p1 = 0; r1 = '0; done1_in = 1'b0; dout1 = '0;
    forever begin
      @(negedge clk);
      done1_in = 1'b0;
      if (cs0) n0++;
      if (reset) p1 = 0;
      else begin
        if (p1) begin done1_in = 1'b1; dout1 = r1; p1 = 0; end
        if (cs1) begin
          p1 = 1; r1 = cdin1 ^ ck1[255:128]; n1++;
          if (cm1 != 2'b00) badmode1++;
        end
      end
    end
  end

  task automatic check_zero(input string name);
    chk(name, {core_start, core_dec, core_mode, busy, done, led256, led192, led128,
               fail_count, signature, core_din}, '0);
    chk({name, "_key"}, core_key, '0);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic do_run(input int flip, input int hang, input bit pokes, output logic [31:0] sig_o);
    logic [2:0] el; logic [7:0] efc; logic [31:0] es; int ne; bit seen;
    model_run(flip, hang, el, efc, es, ne);
    flip_mode = flip; hang_mode = hang; nreq = 0;
    pulse_start();
    chk("busy_after_start", {busy, done}, 2'b10);
    seen = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
      start = pokes && busy && ($urandom_range(0, 7) == 0);
    end
    start = 1'b0;
    chk("done_reached", seen, 1);
    chk("leds", {led256, led192, led128}, el);
    chk("fail_count", fail_count, efc);
    chk("signature", signature, es);
    chk("req_count", nreq, ne);
    chk("queue_drained", expq.size(), 0);
    sig_o = signature;
  endtask

  initial begin
    logic [31:0] sig_a, s;
    bit seen;
    reset = 1'b1; start = 1'b0; start1 = 1'b0; start0 = 1'b0;
    repeat (2) begin @(negedge clk); check_zero("reset_hold"); end
    reset = 1'b0;
    @(negedge clk); check_zero("after_reset");
    chk("no_req_in_reset", nreq, 0);

    do_run(-1, -1, 1'b0, sig_a);
    chk("req_count_12", nreq, 12);
    do_run(1, -1, 1'b0, s);
    chk("flip_leds", {led256, led192, led128, fail_count}, {3'b101, 8'd2});
    do_run(-1, 2, 1'b0, s);
    chk("hang_leds", {led256, led192, led128, fail_count}, {3'b011, 8'd2});
    do_run(-1, -1, 1'b1, s);
    chk("poke_sig", s, sig_a);

    // abort a run in DEC_WAIT
    begin
      logic [2:0] el; logic [7:0] efc; logic [31:0] es; int ne;
      model_run(-1, -1, el, efc, es, ne);
    end
    flip_mode = -1; hang_mode = -1;
    pulse_start();
    seen = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (core_start && core_dec) begin seen = 1; break; end
    end
    chk("dec_req_seen", seen, 1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); check_zero("abort_reset");
    reset = 1'b0;
    expq.delete();
    do_run(-1, -1, 1'b0, s);
    chk("fresh_sig", s, sig_a);

    // single-mode instance
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    seen = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (done1) begin seen = 1; break; end
    end
    chk("m1_done", seen, 1);
    chk("m1_leds_fc", {l256_1, l192_1, l128_1, fc1}, {3'b001, 8'd0});
    chk("m1_req_count", n1, 2 * NV);
    chk("m1_bad_mode", badmode1, 0);

    // empty-mask instance
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    chk("m0_done_next", {done0, busy0, l256_0, l192_0, l128_0, fc0}, {5'b10000, 8'd0});
    @(negedge clk);
    chk("m0_no_req", n0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
